pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch stage of the processor. Holds the architectural PC, issues single-cycle requests to instruction memory, and presents each fetched instruction to decode through a valid/ready handshake. Its `pc_plus4` output feeds the `dato1` input of the downstream next-PC 2:1 selector. That selector's output (PC+4 or branch/jump target) returns as `pc_next` and is loaded when an instruction is consumed or on a flush.

## Interface
- `size`, 32: PC and address width in bits.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset. Must be word aligned.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pc_next` input size: next PC from the 2:1 selector (`salida`).
- `flush` input 1: redirect request; discard the current fetch and load `pc_next`.
- `imem_ack` input 1: instruction memory has driven `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word from memory.
- `instr_ready` input 1: decode accepts `instr` this cycle.
- `imem_req` output 1: fetch request.
- `imem_addr` output size: fetch address; always equals `pc`.
- `pc` output size: address of the instruction being fetched or held.
- `pc_plus4` output size: `pc + 4`, combinational, modulo 2^size.
- `instr` output 32: held instruction word.
- `instr_valid` output 1: `instr` and `pc` are valid for decode.
- `misalign` output 1: sticky error flag. Exists only with `PC_ALIGN_CHECK_EN`.

## Operation
- FSM has three states: IDLE, REQ, VALID.
- **IDLE** (reset state):
  - `imem_req=0`, `instr_valid=0`.
  - Goes unconditionally to REQ on the next cycle.
- **REQ**:
  - `imem_req=1`, `imem_addr=pc`.
  - If `imem_ack`: capture `imem_rdata` into `instr` and go to VALID.
  - Otherwise stay in REQ. Request and address stay stable.
- **VALID**:
  - `instr_valid=1`.
  - If `instr_ready`: `pc <= pc_next` and go to REQ.
  - Otherwise hold `instr` and `pc` unchanged.
- **flush** in REQ or VALID takes priority over everything else:
  - `pc <= pc_next` and go to REQ.
  - An `imem_ack` in the same cycle is dropped (`instr` not updated).
  - `instr_valid` falls on the next cycle.
- flush in IDLE is ignored.
- Memory protocol has no outstanding transactions. `ack` is meaningful only while `req=1`. An `ack` with `req=0` is ignored.
- Wrap-around: `pc_plus4` of 32'hFFFF_FFFC is 32'h0000_0000. No overflow flag.
- Reset outputs:
  - `pc=RESET_PC`, `instr=32'h0000_0013` (NOP).
  - `imem_req=0`, `instr_valid=0`, `misalign=0`.
- Reset mid-operation: abandons any request or held instruction. The next cycle is IDLE.

## Timing
- Reset sampled high at edge N: outputs hold reset values after N.
- Reset released before edge N+1: IDLE during cycle N+1, REQ at N+2.
- With `ack` in the REQ cycle, `instr_valid` is high on the next cycle. Fetch-to-valid latency is 1 cycle plus memory wait cycles.
- Maximum throughput is one instruction per 2 cycles (REQ, VALID).
- `pc_next` is sampled only at an edge where (VALID and `instr_ready`) or `flush`.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A `pc_next` with `pc_next[1:0]!=0` sampled on a load is not loaded. `pc` keeps its value.
  - The FSM enters IDLE and stays there, with `misalign` set sticky, until reset.
- Not defined:
  - `pc_next[1:0]` is forced to 2'b00 on load.
  - The `misalign` port is absent.

## Test plan
- Reset with `RESET_PC`=32'h100, `ack` tied 1 → cycle after IDLE `imem_req=1`, `imem_addr`=32'h100. Next cycle `instr_valid=1` with `instr`=`imem_rdata`. `pc_plus4`=32'h104.
- `ack` delayed 3 cycles → `imem_req` and `imem_addr` held stable for 3 cycles, then `instr_valid=1` one cycle after `ack`.
- VALID with `instr_ready=0` for 4 cycles → `instr`/`pc` unchanged. On `instr_ready=1` with `pc_next`=32'h200 → next cycle REQ at 32'h200.
- `flush` with `pc_next`=32'h40 in the same cycle as `ack` → data dropped, `instr_valid=0`, next request at 32'h40.
- `pc`=32'hFFFF_FFFC → `pc_plus4`=32'h0. Reset asserted in VALID → `instr_valid=0` and `pc=RESET_PC` after that edge.
- With `PC_ALIGN_CHECK_EN`, `pc_next`=32'h102 on accept → `misalign=1`, `imem_req` stays 0, `pc` unchanged until reset. Without the macro → `pc`=32'h100.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: imem request/response, decode handshake and next-PC feedback.
// Master is the fetch stage; slave is the memory/decode/selector side.
interface pc_fetch_if #(
  parameter int size = 32
);
  logic [size-1:0] pc_next;
  logic            flush;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_ready;
  logic            imem_req;
  logic [size-1:0] imem_addr;
  logic [size-1:0] pc;
  logic [size-1:0] pc_plus4;
  logic [31:0]     instr;
  logic            instr_valid;

  modport master (
    input  pc_next,
    input  flush,
    input  imem_ack,
    input  imem_rdata,
    input  instr_ready,
    output imem_req,
    output imem_addr,
    output pc,
    output pc_plus4,
    output instr,
    output instr_valid
  );

  modport slave (
    output pc_next,
    output flush,
    output imem_ack,
    output imem_rdata,
    output instr_ready,
    input  imem_req,
    input  imem_addr,
    input  pc,
    input  pc_plus4,
    input  instr,
    input  instr_valid
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register and instruction fetch stage (IDLE/REQ/VALID FSM).
// Optional PC_ALIGN_CHECK_EN: misaligned pc_next halts fetch with sticky misalign.
module pc_fetch #(
  parameter int          size     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PC_ALIGN_CHECK_EN
  output logic       misalign,
`endif
  pc_fetch_if.master bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID
  } state_t;

  state_t          state;
  logic [size-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            valid_q;

  logic            do_load;
  logic            bad;
  logic            stop;
  logic [size-1:0] load_pc;

  assign do_load = (state == REQ && bus.flush) ||
                   (state == VALID && (bus.flush || bus.instr_ready));

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;

  assign bad     = bus.pc_next[1:0] != 2'b00;
  assign load_pc = bus.pc_next;
  assign stop    = misalign_q;
  assign misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (do_load && bad)
      misalign_q <= 1'b1;
  end
`else
  assign bad     = 1'b0;
  assign load_pc = bus.pc_next & ~size'(3);
  assign stop    = 1'b0;
`endif

  // flush/accept overrides the per-state update below
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= size'(RESET_PC);
      instr_q <= NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (!bus.flush && bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            state   <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: ;
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
      if (do_load) begin
        valid_q <= 1'b0;
        if (bad) begin
          state <= IDLE;
          req_q <= 1'b0;
        end else begin
          pc_q  <= load_pc;
          state <= REQ;
          req_q <= 1'b1;
        end
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + size'(4);
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetches/handoffs queued by stimulus,
// popped by a negedge monitor; direct checks cover holds, flush and reset.
module tb_pc_fetch;

  logic clk = 1'b0;
  logic reset;
`ifdef PC_ALIGN_CHECK_EN
  logic misalign;
`endif

  pc_fetch_if #(.size(32)) bus ();

  pc_fetch #(
    .size(32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef PC_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_out[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: accepted fetches and decode handoffs
  always @(negedge clk) begin
    if (!reset && !bus.flush) begin
      if (bus.imem_req && bus.imem_ack) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got addr %h expected none",
                   bus.imem_addr);
        end else begin
          logic [31:0] e;
          e = exp_req.pop_front();
          if (bus.imem_addr !== e) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", bus.imem_addr, e);
          end
        end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got pc %h instr %h expected none",
                   bus.pc, bus.instr);
        end else begin
          logic [63:0] e;
          e = exp_out.pop_front();
          if ({bus.pc, bus.instr} !== e) begin
            errors++;
            $display("FAIL out_pc_instr: got %h_%h expected %h_%h",
                     bus.pc, bus.instr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.pc_next     = 32'h0;
    bus.flush       = 1'b0;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'h0000_00A0;
    bus.instr_ready = 1'b0;
    step();
    step();
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_instr", bus.instr, 32'h13);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_plus4", bus.pc_plus4, 32'h104);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
`endif

    // ack tied high: REQ after IDLE, VALID next cycle
    reset = 1'b0;
    exp_req.push_back(32'h100);
    step();
    chk("req_after_idle", {31'b0, bus.imem_req}, 32'h1);
    chk("req_addr_100", bus.imem_addr, 32'h100);
    step();
    chk("valid_first", {31'b0, bus.instr_valid}, 32'h1);
    chk("instr_first", bus.instr, 32'hA0);

    // stall in VALID; stray ack/rdata must not disturb held data
    bus.imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_instr", bus.instr, 32'hA0);
      chk("hold_pc", bus.pc, 32'h100);
    end

    // accept with pc_next=200, memory then waits 3 cycles
    bus.instr_ready = 1'b1;
    bus.pc_next     = 32'h200;
    bus.imem_ack    = 1'b0;
    exp_out.push_back({32'h100, 32'hA0});
    step();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'b0, bus.imem_req}, 32'h1);
      chk("wait_addr", bus.imem_addr, 32'h200);
      chk("wait_valid", {31'b0, bus.instr_valid}, 32'h0);
      step();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_00B0;
    exp_req.push_back(32'h200);
    step();
    chk("valid_after_wait", {31'b0, bus.instr_valid}, 32'h1);
    chk("instr_b0", bus.instr, 32'hB0);

    // consume, then flush coincident with ack
    bus.instr_ready = 1'b1;
    bus.pc_next     = 32'h300;
    bus.imem_ack    = 1'b0;
    exp_out.push_back({32'h200, 32'hB0});
    step();
    bus.instr_ready = 1'b0;
    bus.flush       = 1'b1;
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    bus.pc_next     = 32'h40;
    step();
    bus.flush    = 1'b0;
    bus.imem_ack = 1'b0;
    chk("flush_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("flush_instr", bus.instr, 32'hB0);
    chk("flush_req", {31'b0, bus.imem_req}, 32'h1);
    chk("flush_addr", bus.imem_addr, 32'h40);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_00C0;
    exp_req.push_back(32'h40);
    step();
    chk("instr_c0", bus.instr, 32'hC0);

    // flush from VALID to top of address space
    bus.imem_ack = 1'b0;
    bus.flush    = 1'b1;
    bus.pc_next  = 32'hFFFF_FFFC;
    step();
    bus.flush = 1'b0;
    chk("vflush_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.pc_plus4, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_00D0;
    exp_req.push_back(32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'b0, bus.instr_valid}, 32'h1);

    // reset while VALID
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("mid_rst_pc", bus.pc, 32'h100);
    chk("mid_rst_instr", bus.instr, 32'h13);
    chk("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    reset          = 1'b0;
    bus.imem_rdata = 32'h0000_00E0;
    exp_req.push_back(32'h100);
    step();
    step();
    chk("refetch_instr", bus.instr, 32'hE0);

    // accept a misaligned pc_next
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    bus.pc_next     = 32'h102;
    exp_out.push_back({32'h100, 32'hE0});
    step();
    bus.instr_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mis_flag", {31'b0, misalign}, 32'h1);
      chk("mis_req", {31'b0, bus.imem_req}, 32'h0);
      chk("mis_pc", bus.pc, 32'h100);
      step();
    end
    bus.flush = 1'b0;
`else
    chk("align_pc", bus.pc, 32'h100);
    chk("align_req", {31'b0, bus.imem_req}, 32'h1);
`endif
    step();
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("out_queue_empty", exp_out.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
